decoder_rr_arbiter: RTL
=======================

Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares one active-low 2-to-4 select decoder, and the resource behind it, among four requesters. It sequences the decoder's select pair and enable, and mirrors the decoded active-low grant lines. It sits between requesting units (ALU, register file, I/O port, fetch) and the decoder that gates their bus drivers. A grant is held while its requester keeps its request asserted, with optional forced release.

Parameters:
MAX_HOLD, 8, max consecutive cycles one requester may hold the grant (range 2..255; used only with timeout feature)
TURNAROUND, 1, idle cycles between release and next grant (0 or 1 only)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
req  input  4  request lines, active-high, req[i] from requester i
sel  output  2  decoder select {A,B} = index of granted requester
en  output  1  decoder enable, 1 while a grant is active
grant_n  output  4  active-low grants, grant_n[i]=0 means requester i owns resource
busy  output  1  1 in GRANT or RELEASE state
timeout  output  1  one-cycle pulse on forced release (tied 0 without feature)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. All outputs registered.
- Reset values: state=IDLE, sel=2'b00, en=0, grant_n=4'b1111, busy=0, timeout=0, last-winner pointer=3 (requester 0 has top priority first), hold counter=0.
- Reset asserted mid-grant: at the next rising edge all outputs take reset values; no partial release cycle.
- Output invariant every cycle: en=1 -> grant_n = ~(4'b0001 << sel); en=0 -> grant_n=4'b1111. At most one grant_n bit low.
- Arbitration: scan starts at (last+1) mod 4 and wraps cyclically. The first set req bit wins. last <= winner on every grant.
- States:
  - IDLE: en=0. If req!=0, go to GRANT with sel=winner, en=1. Latency is 1 cycle: req sampled at edge N, grant visible after edge N.
  - GRANT: hold sel/en while req[sel]=1. Changes on other req bits are ignored. When req[sel]=0 is sampled:
    - TURNAROUND=1: go to RELEASE.
    - TURNAROUND=0: arbitrate in the same cycle. Go to GRANT with the new winner back-to-back, or to IDLE if req==0. The dropping requester is excluded by the pointer.
  - RELEASE: en=0, grant_n=1111, busy=1 for exactly one cycle. Arbitrate; go to GRANT if req!=0, else IDLE.
- Hold counter: cleared on entry to GRANT, increments each GRANT cycle, saturates at MAX_HOLD-1. Its width is the minimum needed for MAX_HOLD-1.
- Simultaneous requests in IDLE: the pointer decides. After reset, req=4'b1111 grants 0, then 1, 2, 3, 0.
- A requester that drops and reasserts while another holds the grant waits for its round-robin turn.

Optional Feature:
ARB_HOLD_TIMEOUT_EN
- Defined: if the hold counter equals MAX_HOLD-1 and req[sel] is still 1 at a rising edge, the grant is forcibly released.
  - The transition is the same as a request drop (RELEASE, or immediate re-arbitration if TURNAROUND=0).
  - timeout pulses 1 for the first cycle after the release.
  - The pointer advances past the evicted requester. If it is the sole requester, it is regranted after turnaround.
- Undefined: no counter logic, timeout tied 0, and a grant is held indefinitely while req[sel]=1.

Test Plan:
- Reset with req=4'b0000 held 3 cycles -> sel=00, en=0, grant_n=1111, busy=0. Then release reset with req=4'b0100 -> one cycle later sel=10, en=1, grant_n=1011.
- After reset, req=4'b1111 held constant, each requester drops its req after 2 grant cycles (TURNAROUND=1) -> grant order 0,1,2,3,0, each separated by one cycle of grant_n=1111.
- TURNAROUND=0: requester 1 granted, req goes 0010->1000 in one cycle -> next cycle sel=11, grant_n=0111 with no idle gap.
- Requester 3 granted, req[0] toggles 0/1 every cycle -> grant_n stays 0111 until req[3]=0. Then requester 0 wins.
- With ARB_HOLD_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held, requester 0 first -> requester 0 is released after 4 grant cycles with a timeout pulse, then requester 1 is granted. Without the macro, requester 0 holds indefinitely and timeout=0.
- rst_n driven 0 during GRANT of requester 2 -> at the next edge grant_n=1111, en=0. After release with req=4'b0110, requester 1 is granted, confirming pointer reset.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that sequences a shared active-low 2-to-4 decoder for four requesters.
// Define ARB_HOLD_TIMEOUT_EN to enable forced release after MAX_HOLD consecutive grant cycles.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic       en,
  output logic [3:0] grant_n,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("decoder_rr_arbiter: MAX_HOLD must be in 2..255");
  end
  if (TURNAROUND != 0 && TURNAROUND != 1) begin : g_bad_turnaround
    $error("decoder_rr_arbiter: TURNAROUND must be 0 or 1");
  end

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic [3:0] grant_n_q, grant_n_d;
  logic       busy_q, busy_d;
  logic [1:0] last_q, last_d;

  logic [1:0] winner;
  logic       found;
  logic       forced;
  logic       takeGrant;
  logic       goRelease;
  logic       goIdle;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Eviction fires only while the owner is still requesting; a plain drop takes priority.
  assign forced  = (state_q == GRANT) && req[sel_q] && (cnt_q == CNT_MAX);
  assign timeout = timeout_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Cyclic scan starting one past the last winner, so the previous owner ranks lowest.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req[2'(last_q + 2'(i))]) begin
        winner = 2'(last_q + 2'(i));
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    takeGrant = 1'b0;
    goRelease = 1'b0;
    goIdle    = 1'b0;
    case (state_q)
      IDLE: takeGrant = found;
      GRANT: begin
        if (!req[sel_q] || forced) begin
          if (TURNAROUND != 0) begin
            goRelease = 1'b1;
          end else if (found) begin
            takeGrant = 1'b1;
          end else begin
            goIdle = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (found) begin
          takeGrant = 1'b1;
        end else begin
          goIdle = 1'b1;
        end
      end
      default: goIdle = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    en_d      = en_q;
    grant_n_d = grant_n_q;
    busy_d    = busy_q;
    last_d    = last_q;
`ifdef ARB_HOLD_TIMEOUT_EN
    timeout_d = forced;
    cnt_d     = cnt_q;
    if (state_q == GRANT && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (takeGrant) begin
      cnt_d = '0;
    end
`endif
    if (takeGrant) begin
      state_d   = GRANT;
      sel_d     = winner;
      en_d      = 1'b1;
      grant_n_d = ~(4'b0001 << winner);
      busy_d    = 1'b1;
      last_d    = winner;
    end else if (goRelease) begin
      state_d   = RELEASE;
      en_d      = 1'b0;
      grant_n_d = 4'b1111;
      busy_d    = 1'b1;
    end else if (goIdle) begin
      state_d   = IDLE;
      en_d      = 1'b0;
      grant_n_d = 4'b1111;
      busy_d    = 1'b0;
    end
  end

  // Reset wins outright, so a grant cut short by reset never shows a release cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      en_q      <= 1'b0;
      grant_n_q <= 4'b1111;
      busy_q    <= 1'b0;
      last_q    <= 2'd3;
`ifdef ARB_HOLD_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= en_d;
      grant_n_q <= grant_n_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign sel     = sel_q;
  assign en      = en_q;
  assign grant_n = grant_n_q;
  assign busy    = busy_q;

endmodule
